// File: rtl/sequence_differencer.sv
// Recovers raw samples from a stream of W-wide window sums.
// x[t] = y[t] - y[t-1] + x[t-W], all modulo 2**DW.
module sequence_differencer #(
  parameter int N  = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_sum,
  output logic          out_valid,
  output logic [DW-1:0] out_sample,
  output logic          primed
);

  localparam int W = 1 << N;
  localparam logic [N:0] CNT_MAX = (N+1)'(W);

  logic [DW-1:0] hist [W];
  logic [DW-1:0] y_prev;
  logic [N-1:0]  ptr;
  logic [N:0]    cnt;
  logic [DW-1:0] x;

  // hist[ptr] still holds x[t-W] here; it is overwritten at the edge
  assign x = in_sum - y_prev + hist[ptr];

  assign primed = (cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      y_prev     <= '0;
      ptr        <= '0;
      cnt        <= '0;
      out_valid  <= 1'b0;
      out_sample <= '0;
      for (int i = 0; i < W; i++) begin
        hist[i] <= '0;
      end
    end else if (in_valid) begin
      hist[ptr]  <= x;
      ptr        <= ptr + 1'b1;
      y_prev     <= in_sum;
      out_sample <= x;
      out_valid  <= 1'b1;
      if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/sequence_differencer.md
# sequence_differencer

Decoder partner for the windowed sequence adder. It accepts a stream of window sums, y[t] = x[t] + x[t-1] + ... + x[t-W+1] with W = 2**N and all arithmetic modulo 2**DW, and reconstructs the original sample stream x[t] exactly. It sits on the receive side of a link or test path, after the adder, and recovers raw samples using a W-deep circular history of recovered values and a registered previous-sum.

## Interface
- N, 4, log2 of window length; W = 2**N, N >= 1
- DW, 8, sample and sum data width in bits
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous to clk, active-high
- in_valid  input  1  in_sum carries a new window sum this cycle
- in_sum  input  DW  window sum y[t], modulo 2**DW
- out_valid  output  1  out_sample carries a recovered sample this cycle
- out_sample  output  DW  recovered sample x[t]
- primed  output  1  at least W samples recovered since reset

## Operation
- Recurrence: x[t] = y[t] - y[t-1] + x[t-W], modulo 2**DW.
  - Wrap-around in the subtract and add is intended.
  - There is no saturation and no overflow flag.
- State:
  - y_prev, DW bits.
  - hist, W entries of DW bits, a circular buffer of recovered samples.
  - ptr, N bits, points to the oldest entry, which is x[t-W].
  - cnt, saturating counter, 0..W.
- Zero-history convention: after reset, y_prev = 0 and every hist entry = 0. This matches an encoder whose delay line starts at zero.
- On a cycle with in_valid = 1:
  - x = in_sum - y_prev + hist[ptr].
  - hist[ptr] <= x.
  - ptr <= ptr + 1, wrapping from W-1 to 0.
  - y_prev <= in_sum.
  - out_sample <= x; out_valid <= 1.
  - cnt <= min(cnt + 1, W).
- On a cycle with in_valid = 0:
  - All state holds.
  - out_valid <= 0.
  - out_sample holds its last value.
- primed = (cnt == W), combinational from cnt.
- Read and write of hist[ptr] in the same cycle: the read returns the old content, x[t-W]. The write takes effect for the next access.

## Timing
- Latency: exactly 1 cycle. in_valid/in_sum at edge k produce out_valid/out_sample at edge k+1.
- Throughput: one sample per cycle, sustained, with no backpressure. The block is always ready.
- Gaps in in_valid do not disturb the recurrence. Only valid cycles advance t.
- Reset values, applied at the first clk edge with rst = 1:
  - out_valid = 0, out_sample = 0, primed = 0.
  - y_prev = 0, ptr = 0, cnt = 0, all hist = 0.
- rst has priority over in_valid in the same cycle. The input sample is dropped.
- Reset mid-stream restarts decoding from the zero-history convention. The upstream adder must be reset in the same cycle to stay aligned.
- ptr wraps modulo W. The first reuse of entry 0 occurs on the (W+1)th valid input.
- primed rises in the same cycle as the out_valid of the Wth recovered sample, and stays high until reset.

## Test plan
All scenarios use N = 2 (W = 4) and DW = 8 unless noted.
- Basic: after reset, send in_sum = 1, 3, 6, 10, 14 on consecutive cycles.
  - out_sample = 1, 2, 3, 4, 5, each one cycle after its input.
  - primed goes high with sample 4 (value 4).
- Modular wrap: send in_sum = 200, 44.
  - out_sample = 200, 100.
  - This checks the negative intermediate 44 - 200 = -156, which is 100 mod 256.
- Bubbles: repeat the Basic scenario with in_valid low for 3 cycles between each input.
  - Outputs are identical values.
  - out_valid pulses only once per input.
  - out_sample is held during the gaps.
- Reset mid-stream: send the first 3 Basic sums, assert rst together with in_valid for 1 cycle, then resend 1, 3, 6.
  - Outputs after reset are 1, 2, 3.
  - primed = 0 after reset.
  - The sum presented during reset produces no out_valid.
- Long random, N = 4, DW = 8: drive 1000 random x through a reference 16-tap window-sum model into the DUT with random in_valid gaps.
  - out_sample equals the delayed x bit-exactly.
  - primed is asserted from the 16th output onward.
- Reset values: hold rst for 2 cycles with in_valid = 1 and in_sum = 8'hFF.
  - out_valid, out_sample and primed read 0.
  - The first post-reset in_sum = 7 yields out_sample = 7.
